// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp
// Soft-start / fade controller feeding the 17-bit duty input of the LED/pump
// PWM core. Firmware writes an 8-bit target level. The block then walks the
// duty toward it by STEP duty LSBs every RATE clock cycles, so the actuators
// never see an abrupt change.
//
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   d_in   - CPU write data
//   cs     - peripheral chip select (qualifies rd/wr)
//   addr   - bus address, only addr[4:0] decoded
//   rd     - read strobe
//   wr     - write strobe
//   d_out  - registered read data, valid the edge after the read strobe
//   duty   - current duty to the PWM core
//   busy   - high while a ramp is in progress
//
// Register map (addr[4:0]):
//   0x01 TARGET (rw)  write d_in[7:0] -> target = {level, 9'b0}
//   0x02 RATE   (rw)  clk cycles per step, 0 = jump immediately
//   0x03 STEP   (rw)  duty LSBs per step, writing 0 stores 1
//   0x04 STATUS (r)   {dir, busy}
//   0x05 DUTY   (r)   current duty
//   0x06 CTRL   (w)   bit0 = abort (freeze duty, target <= duty)
`timescale 1ns/1ps

module pwm_duty_ramp #(
    parameter logic [15:0] RATE_RST = 16'd1000,
    parameter logic [16:0] STEP_RST = 17'd512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic [16:0] duty,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN
    } state_t;

    state_t      state, state_next;
    logic [16:0] duty_next;
    logic [16:0] target, target_next;
    logic [15:0] rate;
    logic [16:0] step;
    logic [15:0] cnt, cnt_next;
    logic        dir, dir_next;

    logic [4:0]  reg_addr;
    logic        wr_en, rd_en;
    logic        wr_target, wr_rate, wr_step, abort;
    logic        tick;
    logic [17:0] diff_up, diff_down, sum_up, sum_down;
    logic [31:0] read_data;

    // Upper address and data bits are not decoded; fold them into one
    // deliberately unused net so they are visibly accounted for.
    logic        unused_bits;
    assign unused_bits = ^{addr[31:5], d_in[31:17]};

    // Bus decode: every access is qualified by cs, and only the low five
    // address bits select a register.
    always_comb begin
        reg_addr  = addr[4:0];
        wr_en     = cs && wr;
        rd_en     = cs && rd;
        wr_target = wr_en && (reg_addr == 5'h01);
        wr_rate   = wr_en && (reg_addr == 5'h02);
        wr_step   = wr_en && (reg_addr == 5'h03);
        abort     = wr_en && (reg_addr == 5'h06) && d_in[0];
    end

    // Ramp arithmetic. Everything is done one bit wider than the duty so the
    // differences and the stepped values never wrap. A step is only taken
    // when the distance to the target exceeds the step size, so the stepped
    // value always stays between duty and target.
    always_comb begin
        diff_up   = {1'b0, target} - {1'b0, duty};
        diff_down = {1'b0, duty} - {1'b0, target};
        sum_up    = {1'b0, duty} + {1'b0, step};
        sum_down  = {1'b0, duty} - {1'b0, step};
        tick      = ({1'b0, cnt} >= ({1'b0, rate} - 17'd1));
    end

    // Next-state logic. Priority inside a ramp: abort, then a zero rate
    // (jump straight to target), then target already reached, then a target
    // that has moved to the other side of duty (turn around without stepping,
    // the rate counter keeps running), and finally the normal counted step.
    // The step always uses the target held in the register, so a TARGET write
    // in the same cycle only takes effect from the following edge.
    always_comb begin
        state_next  = state;
        duty_next   = duty;
        cnt_next    = cnt;
        dir_next    = dir;
        target_next = target;

        if (wr_target) begin
            target_next = {d_in[7:0], 9'b0};
        end

        case (state)
            IDLE: begin
                if (abort) begin
                    target_next = duty;
                end else if (target != duty) begin
                    if (rate == 16'd0) begin
                        duty_next = target;
                    end else if (target > duty) begin
                        state_next = RAMP_UP;
                        dir_next   = 1'b1;
                        cnt_next   = 16'd0;
                    end else begin
                        state_next = RAMP_DOWN;
                        dir_next   = 1'b0;
                        cnt_next   = 16'd0;
                    end
                end
            end

            RAMP_UP, RAMP_DOWN: begin
                if (abort) begin
                    target_next = duty;
                    state_next  = IDLE;
                end else if (rate == 16'd0) begin
                    duty_next  = target;
                    state_next = IDLE;
                end else if (target == duty) begin
                    state_next = IDLE;
                end else if ((state == RAMP_UP) && (target < duty)) begin
                    state_next = RAMP_DOWN;
                    dir_next   = 1'b0;
                    cnt_next   = tick ? 16'd0 : cnt + 16'd1;
                end else if ((state == RAMP_DOWN) && (target > duty)) begin
                    state_next = RAMP_UP;
                    dir_next   = 1'b1;
                    cnt_next   = tick ? 16'd0 : cnt + 16'd1;
                end else begin
                    cnt_next = tick ? 16'd0 : cnt + 16'd1;
                    if (tick) begin
                        if (state == RAMP_UP) begin
                            if (diff_up <= {1'b0, step}) begin
                                duty_next  = target;
                                state_next = IDLE;
                            end else begin
                                duty_next = sum_up[16:0];
                            end
                        end else begin
                            if (diff_down <= {1'b0, step}) begin
                                duty_next  = target;
                                state_next = IDLE;
                            end else begin
                                duty_next = sum_down[16:0];
                            end
                        end
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // A new rate restarts the interval from zero.
        if (wr_rate) begin
            cnt_next = 16'd0;
        end
    end

    // Read mux for the register map; unmapped addresses read as zero.
    always_comb begin
        read_data = 32'd0;
        case (reg_addr)
            5'h01:   read_data = {15'b0, target};
            5'h02:   read_data = {16'b0, rate};
            5'h03:   read_data = {15'b0, step};
            5'h04:   read_data = {30'b0, dir, busy};
            5'h05:   read_data = {15'b0, duty};
            default: read_data = 32'd0;
        endcase
    end

    // State and register file. busy is registered from the next state so it
    // rises on the same edge the ramp starts and falls with the final step.
    // d_out only holds data for the cycle after a read strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            duty   <= 17'd0;
            target <= 17'd0;
            rate   <= RATE_RST;
            step   <= STEP_RST;
            cnt    <= 16'd0;
            dir    <= 1'b0;
            busy   <= 1'b0;
            d_out  <= 32'd0;
        end else begin
            state  <= state_next;
            duty   <= duty_next;
            target <= target_next;
            cnt    <= cnt_next;
            dir    <= dir_next;
            busy   <= (state_next != IDLE);
            d_out  <= rd_en ? read_data : 32'd0;
            if (wr_rate) begin
                rate <= d_in[15:0];
            end
            if (wr_step) begin
                step <= (d_in[16:0] == 17'd0) ? 17'd1 : d_in[16:0];
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed testbench for pwm_duty_ramp. Bus accesses are driven on the
// falling edge and outputs are sampled 1 ns after the rising edge.
`timescale 1ns/1ps

module tb_pwm_duty_ramp;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d_in;
    logic        cs;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_out;
    logic [16:0] duty;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [4:0] A_TARGET = 5'h01;
    localparam logic [4:0] A_RATE   = 5'h02;
    localparam logic [4:0] A_STEP   = 5'h03;
    localparam logic [4:0] A_STATUS = 5'h04;
    localparam logic [4:0] A_DUTY   = 5'h05;
    localparam logic [4:0] A_CTRL   = 5'h06;

    pwm_duty_ramp dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out),
        .duty  (duty),
        .busy  (busy)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Single-cycle bus write; returns 1 ns after the edge that samples it.
    task automatic applyStimulus(input logic [4:0] a, input logic [31:0] data);
        @(negedge clk);
        cs   = 1'b1;
        wr   = 1'b1;
        addr = {27'b0, a};
        d_in = data;
        @(posedge clk);
        #1;
        cs   = 1'b0;
        wr   = 1'b0;
        addr = 32'd0;
        d_in = 32'd0;
    endtask

    // Single-cycle bus read; d_out is valid on return.
    task automatic readReg(input logic [4:0] a);
        @(negedge clk);
        cs   = 1'b1;
        rd   = 1'b1;
        addr = {27'b0, a};
        @(posedge clk);
        #1;
        cs   = 1'b0;
        rd   = 1'b0;
        addr = 32'd0;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cs    = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = 32'd0;
        d_in  = 32'd0;

        // Reset values and register defaults.
        waitEdges(2);
        checkOutput("reset_duty", {15'b0, duty}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_dout", d_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        readReg(A_RATE);
        checkOutput("rd_rate_rst", d_out, 32'd1000);
        readReg(A_STEP);
        checkOutput("rd_step_rst", d_out, 32'd512);
        readReg(A_STATUS);
        checkOutput("rd_status_rst", d_out, 32'd0);
        waitEdges(1);
        checkOutput("dout_clears", d_out, 32'd0);

        // Ramp up 0 -> 2048 with rate 4, step 512.
        applyStimulus(A_RATE, 32'd4);
        applyStimulus(A_TARGET, 32'h04);
        waitEdges(1);
        checkOutput("up_busy_n1", {31'b0, busy}, 32'd1);
        checkOutput("up_duty_n1", {15'b0, duty}, 32'd0);
        waitEdges(4);
        checkOutput("up_duty_n5", {15'b0, duty}, 32'd512);
        waitEdges(4);
        checkOutput("up_duty_n9", {15'b0, duty}, 32'd1024);
        waitEdges(4);
        checkOutput("up_duty_n13", {15'b0, duty}, 32'd1536);
        waitEdges(3);
        checkOutput("up_busy_n16", {31'b0, busy}, 32'd1);
        waitEdges(1);
        checkOutput("up_duty_n17", {15'b0, duty}, 32'd2048);
        checkOutput("up_busy_n17", {31'b0, busy}, 32'd0);
        readReg(A_DUTY);
        checkOutput("rd_duty_2048", d_out, 32'd2048);

        // Ramp down 2048 -> 512 with step 700; final step is clipped.
        applyStimulus(A_STEP, 32'd700);
        applyStimulus(A_TARGET, 32'h01);
        waitEdges(5);
        checkOutput("dn_duty_n5", {15'b0, duty}, 32'd1348);
        readReg(A_STATUS);
        checkOutput("dn_status", d_out, 32'd1);
        waitEdges(3);
        checkOutput("dn_duty_n9", {15'b0, duty}, 32'd648);
        checkOutput("dn_busy_n9", {31'b0, busy}, 32'd1);
        waitEdges(4);
        checkOutput("dn_duty_n13", {15'b0, duty}, 32'd512);
        checkOutput("dn_busy_n13", {31'b0, busy}, 32'd0);

        // Rate 0: immediate jump to the maximum level.
        applyStimulus(A_RATE, 32'd0);
        applyStimulus(A_TARGET, 32'hFF);
        waitEdges(1);
        checkOutput("jump_duty", {15'b0, duty}, 32'd130560);
        checkOutput("jump_busy", {31'b0, busy}, 32'd0);
        waitEdges(1);
        checkOutput("jump_hold", {15'b0, duty}, 32'd130560);

        // Turn-around: ramp up toward 0x80, retarget below duty mid-ramp.
        applyStimulus(A_TARGET, 32'h01);
        applyStimulus(A_STEP, 32'd512);
        applyStimulus(A_RATE, 32'd4);
        checkOutput("ta_start_duty", {15'b0, duty}, 32'd512);
        applyStimulus(A_TARGET, 32'h80);
        readReg(A_STATUS);
        checkOutput("ta_status_n1", d_out, 32'd0);
        readReg(A_STATUS);
        checkOutput("ta_status_n2", d_out, 32'd3);
        waitEdges(3);
        checkOutput("ta_duty_n5", {15'b0, duty}, 32'd1024);
        applyStimulus(A_TARGET, 32'h01);
        waitEdges(1);
        checkOutput("ta_duty_n7", {15'b0, duty}, 32'd1024);
        checkOutput("ta_busy_n7", {31'b0, busy}, 32'd1);
        readReg(A_STATUS);
        checkOutput("ta_status_n8", d_out, 32'd1);
        waitEdges(1);
        checkOutput("ta_duty_n9", {15'b0, duty}, 32'd512);
        checkOutput("ta_busy_n9", {31'b0, busy}, 32'd0);
        applyStimulus(A_STEP, 32'd0);
        readReg(A_STEP);
        checkOutput("rd_step_zero", d_out, 32'd1);

        // Abort on the same edge as a step tick: duty must not move.
        applyStimulus(A_STEP, 32'd512);
        applyStimulus(A_TARGET, 32'h10);
        waitEdges(5);
        checkOutput("ab_duty_n5", {15'b0, duty}, 32'd1024);
        waitEdges(3);
        applyStimulus(A_CTRL, 32'd1);
        checkOutput("ab_duty_n9", {15'b0, duty}, 32'd1024);
        checkOutput("ab_busy_n9", {31'b0, busy}, 32'd0);
        readReg(A_TARGET);
        checkOutput("ab_rd_target", d_out, 32'd1024);
        waitEdges(1);
        checkOutput("ab_duty_hold", {15'b0, duty}, 32'd1024);

        // Reset in the middle of a ramp.
        applyStimulus(A_TARGET, 32'h10);
        waitEdges(5);
        checkOutput("rs_duty_p5", {15'b0, duty}, 32'd1536);
        @(negedge clk);
        reset = 1'b1;
        waitEdges(1);
        checkOutput("rs_duty", {15'b0, duty}, 32'd0);
        checkOutput("rs_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        readReg(A_TARGET);
        checkOutput("rs_rd_target", d_out, 32'd0);
        readReg(A_RATE);
        checkOutput("rs_rd_rate", d_out, 32'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
Bus-attached soft-start/fade controller that sits directly upstream of the LED/pump PWM core. It drives that core's 17-bit duty input. Firmware writes an 8-bit target level, and the block walks the duty toward it in programmable steps at a programmable rate. This avoids inrush and abrupt actuator changes in the water-treatment module.

Parameters:
RATE_RST, 16'd1000, reset value of the RATE register (clk cycles per step)
STEP_RST, 17'd512, reset value of the STEP register (duty LSBs per step)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
d_in  input  32  write data from CPU bus
cs  input  1  peripheral chip select
addr  input  32  bus address; only addr[4:0] decoded
rd  input  1  read strobe, qualified by cs
wr  input  1  write strobe, qualified by cs
d_out  output  32  registered read data
duty  output  17  current duty, wired to the PWM core duty input
busy  output  1  high while a ramp is in progress

Behaviour:
- Reset (synchronous, active-high; clock clk): duty=0, target=0, rate=RATE_RST, step=STEP_RST, state=IDLE, cnt=0, dir=0, d_out=0, busy=0. Reset asserted mid-ramp forces these values at the next edge.
- Register map (addr[4:0]), writes on cs&&wr:
  - 0x01 TARGET: target <= {d_in[7:0], 9'b0}.
  - 0x02 RATE: rate <= d_in[15:0]; cnt <= 0.
  - 0x03 STEP: step <= d_in[16:0]; a written value of 0 stores 1.
  - 0x06 CTRL: when d_in[0]=1 (abort), target <= duty and state <= IDLE.
  - Writes to other addresses are ignored.
- Reads on cs&&rd; d_out is registered and valid the edge after the strobe:
  - 0x01 target; 0x02 {16'b0, rate}; 0x03 {15'b0, step}; 0x04 STATUS {30'b0, dir, busy}; 0x05 {15'b0, duty}.
  - Unmapped address -> 0.
  - d_out <= 0 on any cycle without cs&&rd.
- State machine: IDLE, RAMP_UP, RAMP_DOWN. busy = (state != IDLE), registered.
- IDLE:
  - target == duty: stay.
  - rate == 0: duty <= target, stay IDLE (immediate jump).
  - target > duty: go RAMP_UP, dir=1, cnt=0.
  - target < duty: go RAMP_DOWN, dir=0, cnt=0.
- RAMP_x, each cycle:
  - Tick: tick = (cnt >= rate-1). On tick cnt <= 0, otherwise cnt++.
  - Step on tick: if |target-duty| <= step, then duty <= target and go IDLE. Otherwise duty <= duty ± step in the current direction.
  - The final step lands exactly on target; duty never overshoots, never wraps below 0, never exceeds 17'h1FE00.
  - Direction check: if target has crossed to the other side of duty (target rewritten), switch state/dir at that edge without stepping; cnt continues.
  - If target == duty (rewritten to current value), go IDLE.
  - rate rewritten to 0 mid-ramp: duty <= target at the next edge, go IDLE.
- Latency: TARGET write sampled at edge N; busy=1 from edge N+1; first step at edge N+1+rate.
- Simultaneous TARGET write and tick: the step uses the old target; the new target applies from the next edge.
- Simultaneous abort and tick: abort wins; duty is unchanged.
- Arithmetic: 18-bit difference and sum internally; all register fields unsigned.

Test Plan:
1. Assert reset 2 cycles -> duty=0, busy=0, d_out=0; read 0x02 -> 1000, read 0x03 -> 512, read 0x04 -> 0.
2. Write RATE=4, then TARGET=0x04 at edge N -> busy=1 at N+1; duty=512/1024/1536/2048 at N+5/N+9/N+13/N+17; busy=0 at N+17; read 0x05 -> 2048.
3. From duty 2048: STEP=700, TARGET=0x01 -> duty steps 1348, 648, 512; STATUS dir=0 during the ramp; busy drops with the 512 step.
4. RATE=0, TARGET=0xFF -> duty=130560 one edge after the write; busy stays 0.
5. RATE=4, ramp up to 0x80; at duty 1024 write TARGET=0x01 -> next edge state RAMP_DOWN, dir=0, no step that edge; duty reaches 512 and idles. Then write STEP=0 and read 0x03 -> 1.
6. Mid-ramp write CTRL=1 -> duty frozen, busy=0 next edge, read 0x01 == duty. Restart the ramp and assert reset mid-ramp -> duty=0, busy=0 next edge.
